// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and types for the 2R1W register file,
// its bus interface and the bench.
package reg_file_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_DEPTH  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// intf_reg: decode-side request bundle and execute-side operands
// of the 2R1W register file.
interface intf_reg;
  import reg_file_pkg::*;

  reg_addr_t ReadRegister1;
  reg_addr_t ReadRegister2;
  reg_addr_t WriteRegister;
  reg_data_t WriteData;
  logic      RegWrite;
  reg_data_t ReadData1;
  reg_data_t ReadData2;

  modport master (
    output ReadRegister1,
    output ReadRegister2,
    output WriteRegister,
    output WriteData,
    output RegWrite,
    input  ReadData1,
    input  ReadData2
  );

  modport slave (
    input  ReadRegister1,
    input  ReadRegister2,
    input  WriteRegister,
    input  WriteData,
    input  RegWrite,
    output ReadData1,
    output ReadData2
  );

endinterface

// File: rtl/reg_file_2r1w_read_port.sv
// reg_file_read_port: one registered read port with write bypass
// and optional hardwired-zero entry 0.
module reg_file_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wen_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic              hit;
  logic              zero_hit;

  assign hit      = wen_i && (waddr_i == raddr_i);
  assign zero_hit = ZERO_REG && (raddr_i == '0);

  always_comb begin
    rdata_d = mem_data_i;
    unique case (1'b1)
      zero_hit: rdata_d = '0;
      hit:      rdata_d = wdata_i;
      default:  rdata_d = mem_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32x32 flop-array register file, two registered
// read ports with new-data bypass, one write port.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input logic     clk,
  input logic     reset,
  intf_reg.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic [DATA_W-1:0] rd1_mem;
  logic [DATA_W-1:0] rd2_mem;

  // writes to a hardwired-zero entry are dropped before they reach storage or bypass
  assign wr_en = bus.RegWrite &&
                 !(ZERO_REG && (bus.WriteRegister == '0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[bus.WriteRegister] <= bus.WriteData;
    end
  end

  assign rd1_mem = mem_q[bus.ReadRegister1];
  assign rd2_mem = mem_q[bus.ReadRegister2];

  reg_file_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rp1 (
    .clk        (clk),
    .reset      (reset),
    .raddr_i    (bus.ReadRegister1),
    .waddr_i    (bus.WriteRegister),
    .wdata_i    (bus.WriteData),
    .wen_i      (wr_en),
    .mem_data_i (rd1_mem),
    .rdata_o    (bus.ReadData1)
  );

  reg_file_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rp2 (
    .clk        (clk),
    .reset      (reset),
    .raddr_i    (bus.ReadRegister2),
    .waddr_i    (bus.WriteRegister),
    .wdata_i    (bus.WriteData),
    .wen_i      (wr_en),
    .mem_data_i (rd2_mem),
    .rdata_o    (bus.ReadData2)
  );

endmodule
